fp16_mac_acc: RTL and testbench

- Pipelined IEEE-754 binary16 multiply-accumulate.
- Each cycle it samples operands A and B, forms A×B, and adds the product into a running binary16 accumulator.
- Acc_Out exposes the accumulator register directly.
- Used as a streaming dot-product engine: no handshake, throughput one product per clock.

---
 rtl/fp16_pkg.sv | 47 ++++
 rtl/fp16_add_rne.sv | 81 ++++++++
 rtl/fp16_mac_acc.sv | 123 ++++++++++++
 tb/tb_fp16_mac_acc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 definitions: field layout, special encodings and classification helpers
// used by the multiply pipeline and the accumulator adder.
package fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int SIG_W    = FRAC_W + 1;
    localparam int EXP_BIAS = 15;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [15:0] FP16_MAX      = 16'h7BFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    function automatic fp16_t unpack(input logic [15:0] x);
        return fp16_t'(x);
    endfunction

    // A zero exponent field counts as zero, so subnormals are flushed wherever this is used.
    function automatic logic is_zero(input logic [15:0] x);
        return (x[14:10] == 5'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic [15:0] inf_of(input logic sign);
        return sign ? FP16_NEG_INF : FP16_POS_INF;
    endfunction

    function automatic logic is_overflow(input logic signed [7:0] e);
        return e > $signed({3'b000, FP16_MAX[14:10]});
    endfunction

endpackage

// File: rtl/fp16_add_rne.sv
// Combinational binary16 adder, round-to-nearest-even, flush-to-zero, canonical +0 results.
module fp16_add_rne
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    fp16_t             fa, fb, big, sml;
    logic              a_ge, eff_sub;
    logic [4:0]        d;
    logic [13:0]       big_w, sml_w, norm;
    logic [29:0]       ext;
    logic [14:0]       sum;
    logic [3:0]        lz;
    logic              inc;
    logic [10:0]       rnd;
    logic signed [7:0] exp_n, exp_r;
    logic [15:0]       arith;

    // Working significands carry guard, round and sticky bits below the fraction.
    always_comb begin
        fa      = unpack(a);
        fb      = unpack(b);
        a_ge    = a[14:0] >= b[14:0];
        big     = a_ge ? fa : fb;
        sml     = a_ge ? fb : fa;
        d       = big.exp - sml.exp;
        eff_sub = big.sign ^ sml.sign;
        big_w   = {1'b1, big.frac, 3'b000};
        ext     = {1'b1, sml.frac, 3'b000, 16'h0000} >> d;
        sml_w   = 14'd1;
        if (d < 5'd14) begin
            sml_w = ext[29:16] | {13'd0, |ext[15:0]};
        end
        sum   = eff_sub ? ({1'b0, big_w} - {1'b0, sml_w}) : ({1'b0, big_w} + {1'b0, sml_w});
        exp_n = {3'b000, big.exp};
        lz    = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) begin
                lz = 4'(13 - i);
            end
        end
        if (sum[14]) begin
            norm  = {sum[14:2], sum[1] | sum[0]};
            exp_n = exp_n + 8'sd1;
        end else begin
            norm  = sum[13:0] << lz;
            exp_n = exp_n - $signed({4'b0000, lz});
        end
        inc   = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd   = {1'b0, norm[12:3]} + {10'd0, inc};
        exp_r = rnd[10] ? exp_n + 8'sd1 : exp_n;

        if (!norm[13]) begin
            arith = FP16_POS_ZERO;
        end else if (is_overflow(exp_r)) begin
            arith = inf_of(big.sign);
        end else if (exp_r < 8'sd1) begin
            arith = FP16_POS_ZERO;
        end else begin
            arith = {big.sign, exp_r[4:0], rnd[9:0]};
        end

        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[15] != b[15]))) begin
            y = FP16_QNAN;
        end else if (is_inf(a)) begin
            y = a;
        end else if (is_inf(b)) begin
            y = b;
        end else if (is_zero(b)) begin
            y = is_zero(a) ? FP16_POS_ZERO : a;
        end else if (is_zero(a)) begin
            y = b;
        end else begin
            y = arith;
        end
    end

endmodule

// File: rtl/fp16_mac_acc.sv
// Streaming binary16 multiply-accumulate: operands sampled at edge k reach the
// accumulator at edge k+7; one product per clock, no handshake.
module fp16_mac_acc
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Acc_Out
);

    logic [15:0]       a_q, a_d, b_q, b_d;
    logic              m_sign_q, m_sign_d, m_nan_q, m_nan_d;
    logic              m_inf_q, m_inf_d, m_zero_q, m_zero_d;
    logic signed [7:0] m_exp_q, m_exp_d;
    logic [21:0]       m_sig_q, m_sig_d;
    logic [15:0]       prod_q, prod_d;
    logic [15:0]       dly_q [0:3];
    logic [15:0]       dly_d [0:3];
    logic [15:0]       acc_q, acc_d;

    fp16_t             fa, fb;
    logic [9:0]        n_frac;
    logic              n_g, n_s, r_inc;
    logic signed [7:0] n_exp, r_exp;
    logic [10:0]       rnd;

    // Stage 2: classify operands and form the exact 11x11 significand product.
    always_comb begin
        a_d      = A;
        b_d      = B;
        fa       = unpack(a_q);
        fb       = unpack(b_q);
        m_sign_d = fa.sign ^ fb.sign;
        m_nan_d  = is_nan(a_q) || is_nan(b_q) ||
                   (is_inf(a_q) && is_zero(b_q)) || (is_zero(a_q) && is_inf(b_q));
        m_inf_d  = is_inf(a_q) || is_inf(b_q);
        m_zero_d = is_zero(a_q) || is_zero(b_q);
        m_exp_d  = {3'b000, fa.exp} + {3'b000, fb.exp} - 8'(EXP_BIAS);
        m_sig_d  = 22'({1'b1, fa.frac}) * 22'({1'b1, fb.frac});
    end

    // Stage 3: normalise the product, round to nearest even and resolve specials.
    always_comb begin
        if (m_sig_q[21]) begin
            n_frac = m_sig_q[20:11];
            n_g    = m_sig_q[10];
            n_s    = |m_sig_q[9:0];
            n_exp  = m_exp_q + 8'sd1;
        end else begin
            n_frac = m_sig_q[19:10];
            n_g    = m_sig_q[9];
            n_s    = |m_sig_q[8:0];
            n_exp  = m_exp_q;
        end
        r_inc = n_g & (n_s | n_frac[0]);
        rnd   = {1'b0, n_frac} + {10'd0, r_inc};
        r_exp = rnd[10] ? n_exp + 8'sd1 : n_exp;

        if (m_nan_q) begin
            prod_d = FP16_QNAN;
        end else if (m_inf_q) begin
            prod_d = inf_of(m_sign_q);
        end else if (m_zero_q) begin
            prod_d = {m_sign_q, 15'd0};
        end else if (is_overflow(r_exp)) begin
            prod_d = inf_of(m_sign_q);
        end else if (r_exp < 8'sd1) begin
            prod_d = {m_sign_q, 15'd0};
        end else begin
            prod_d = {m_sign_q, r_exp[4:0], rnd[9:0]};
        end
    end

    always_comb begin
        dly_d[0] = prod_q;
        for (int i = 1; i < 4; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    fp16_add_rne u_add (
        .a (acc_q),
        .b (dly_q[3]),
        .y (acc_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= FP16_POS_ZERO;
            b_q      <= FP16_POS_ZERO;
            m_sign_q <= 1'b0;
            m_nan_q  <= 1'b0;
            m_inf_q  <= 1'b0;
            m_zero_q <= 1'b1;
            m_exp_q  <= 8'sd0;
            m_sig_q  <= 22'd0;
            prod_q   <= FP16_POS_ZERO;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= FP16_POS_ZERO;
            end
            acc_q    <= FP16_POS_ZERO;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            m_sign_q <= m_sign_d;
            m_nan_q  <= m_nan_d;
            m_inf_q  <= m_inf_d;
            m_zero_q <= m_zero_d;
            m_exp_q  <= m_exp_d;
            m_sig_q  <= m_sig_d;
            prod_q   <= prod_d;
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= dly_d[i];
            end
            acc_q    <= acc_d;
        end
    end

    assign Acc_Out = acc_q;

endmodule

// File: tb/tb_fp16_mac_acc.sv
// Scoreboard bench for fp16_mac_acc: stimulus queues hand-computed accumulator values
// tagged with the edge after which they must appear; a negedge monitor checks them.
module tb_fp16_mac_acc;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Acc_Out;

    int edge_cnt = 0;
    int n_cmp    = 0;
    int n_err    = 0;

    typedef struct {
        int          due;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    fp16_mac_acc dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .Acc_Out (Acc_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string tag, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: Acc_Out=%h required %h (edge %0d)", tag, act, req, edge_cnt);
        end
    endtask

    task automatic expect_at(input int due, input logic [15:0] val, input string tag);
        exp_t e;
        e.due = due;
        e.val = val;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: Acc_Out after edge n is valid at the following negedge.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= edge_cnt) begin
                check_output(sb_q[i].tag, Acc_Out, sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    task automatic apply_raw(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        A = a;
        B = b;
    endtask

    // Operands driven now are sampled at edge_cnt+1 and land in the accumulator at edge_cnt+8.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] acc_after, input string tag);
        apply_raw(a, b);
        expect_at(edge_cnt + 8, acc_after, tag);
    endtask

    task automatic drain();
        int budget = 0;
        while (sb_q.size() > 0 && budget < 40) begin
            @(negedge clk);
            A = 16'h0000;
            B = 16'h0000;
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL drain: %0d expectations still pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        A   = 16'h0000;
        B   = 16'h0000;
        rst = 1'b0;
        #1;
        check_output("reset_async", Acc_Out, 16'h0000);
        @(negedge clk);
        check_output("reset_hold", Acc_Out, 16'h0000);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int target;
        int budget;
        rst = 1'b1;
        A   = 16'h0000;
        B   = 16'h0000;
        #1;
        do_reset();

        // 1.0*1.0 then 2.0*2.0: 1.0 then 5.0, nothing visible before edge 8
        apply_stimulus(16'h3C00, 16'h3C00, 16'h3C00, "t1_first");
        expect_at(edge_cnt + 7, 16'h0000, "t1_before");
        apply_stimulus(16'h4000, 16'h4000, 16'h4500, "t1_second");
        apply_stimulus(16'h0000, 16'h0000, 16'h4500, "t1_idle");
        drain();

        do_reset();
        apply_stimulus(16'hBE00, 16'h4000, 16'hC200, "t2_neg3");
        apply_stimulus(16'h0000, 16'h0000, 16'hC200, "t2_idle");
        drain();

        // Back-to-back accumulation, then adding a +0 product
        do_reset();
        apply_stimulus(16'h3C00, 16'h3C00, 16'h3C00, "t3_acc1");
        apply_stimulus(16'h3C00, 16'h3C00, 16'h4000, "t3_acc2");
        apply_stimulus(16'h3C00, 16'h3C00, 16'h4200, "t3_acc3");
        apply_stimulus(16'h3C00, 16'h3C00, 16'h4400, "t3_acc4");
        apply_stimulus(16'h4500, 16'h0000, 16'h4400, "t3_addzero");
        apply_stimulus(16'h0000, 16'h0000, 16'h4400, "t3_idle");
        drain();

        // 2048 + 1 ties to even and stays 2048
        do_reset();
        apply_stimulus(16'h6800, 16'h3C00, 16'h6800, "t4_2048");
        apply_stimulus(16'h3C00, 16'h3C00, 16'h6800, "t4_tie_even");
        apply_stimulus(16'h0000, 16'h0000, 16'h6800, "t4_idle");
        drain();

        do_reset();
        apply_stimulus(16'h7BFF, 16'h4000, 16'h7C00, "t5_overflow");
        apply_stimulus(16'h3C00, 16'h3C00, 16'h7C00, "t5_inf_sticky");
        apply_stimulus(16'hFC00, 16'h3C00, 16'h7E00, "t5_inf_minus_inf");
        drain();

        do_reset();
        apply_stimulus(16'h7C00, 16'h0000, 16'h7E00, "t6_inf_times_zero");
        apply_stimulus(16'h4000, 16'h4000, 16'h7E00, "t6_nan_sticky");
        drain();

        // Exact cancellation and subnormal flush both give +0
        do_reset();
        apply_stimulus(16'h4000, 16'h3C00, 16'h4000, "t7_two");
        apply_stimulus(16'hC000, 16'h3C00, 16'h0000, "t7_cancel");
        apply_stimulus(16'h0001, 16'h3C00, 16'h0000, "t7_subnormal");
        apply_stimulus(16'h3C00, 16'h3C00, 16'h3C00, "t7_after");
        drain();

        // Reset while three products are still in the pipeline
        do_reset();
        apply_raw(16'h3C00, 16'h3C00);
        target = edge_cnt + 8;
        apply_raw(16'h4000, 16'h4000);
        apply_raw(16'h4000, 16'h3C00);
        apply_raw(16'h3C00, 16'h4000);
        apply_raw(16'h0000, 16'h0000);
        budget = 0;
        while (edge_cnt < target && budget < 20) begin
            @(posedge clk);
            #2;
            budget++;
        end
        check_output("t8_pre_reset", Acc_Out, 16'h3C00);
        rst = 1'b0;
        #1;
        check_output("t8_async_clear", Acc_Out, 16'h0000);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            expect_at(edge_cnt + i, 16'h0000, "t8_post_reset");
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
